irq_priority_controller: RTL
============================

Name: irq_priority_controller

Overview:
- Multi-source interrupt controller placed between external interrupt lines and the multi-cycle MIPS control unit.
- Edge-detects NUM_IRQ maskable lines plus one non-maskable line, holds pending and mask registers, and picks a fixed-priority winner.
- Presents the winner to the core only at an instruction boundary (control_state==0) through a req/ack handshake, then tracks in-service status until end-of-interrupt.
- Supports one level of NMI preemption over a maskable handler.

Parameters:
- NUM_IRQ, 4, number of maskable lines; id 0 has the highest priority.
- MI_VEC_BASE, 32'h00000040, handler address of maskable id 0.
- VEC_STRIDE, 32'h00000010, address spacing between maskable handlers.
- NMI_VECTOR, 32'h00000080, NMI handler address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- irq  in  NUM_IRQ  maskable request lines, rising-edge sensitive.
- nmi  in  1  non-maskable line, rising-edge sensitive.
- control_state  in  4  control-unit FSM state; 0 means fetch, which is the instruction boundary.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  NUM_IRQ  new mask; bit=1 disables that line.
- int_ack  in  1  one-cycle pulse: core has taken the request and jumped to int_vector.
- eoi  in  1  one-cycle pulse: handler has returned.
- int_req  out  1  request to the core.
- int_nmi  out  1  the current request or service is an NMI.
- int_id  out  2  id of the latched maskable winner.
- int_vector  out  32  handler address of the latched winner.
- in_service  out  1  a handler is running.
- pending  out  NUM_IRQ  pending register.
- mask  out  NUM_IRQ  mask register.
- state  out  3  FSM state, for debug.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE; int_req, int_nmi, int_id, int_vector, in_service, pending, nmi_pend, nested=0.
  - mask=all 1s; edge-detect history registers=0.
  - Reset overrides everything, including mid-service.
- Edge detect: pending[i] is set when irq[i] is 1 and its history bit is 0. nmi_pend is set the same way from nmi.
- Set versus clear: if a set and a clear hit the same bit in one cycle, the set wins.
- Mask:
  - mask_we loads mask_wdata on the next edge.
  - A masked line still sets pending but is not eligible.
  - eligible = pending & ~mask.
- Winner: nmi_pend first, then the lowest-index eligible bit.
- Vector: int_vector = NMI_VECTOR for an NMI, otherwise MI_VEC_BASE + id*VEC_STRIDE, computed in 32 bits.
- All outputs are registered.
- FSM states:
  - IDLE (0):
    - Leave only when control_state==0 and (nmi_pend or |eligible).
    - Latch the winner (int_nmi, int_id, int_vector), set int_req=1, go to REQ.
  - REQ (1): int_req is held at 1 and the latched fields stay stable until one of:
    - int_ack: int_req=0; clear the winning pending bit (or nmi_pend); go to NMI_SVC if int_nmi, else MI_SVC; in_service=1.
    - Upgrade: latched winner is maskable and nmi_pend becomes 1 before ack. Relatch to the NMI the next cycle, int_req stays 1, the maskable pending bit stays set.
    - Withdraw: latched winner is maskable and its mask bit becomes 1 before ack. int_req=0, return to IDLE, pending stays set.
  - MI_SVC (2):
    - New maskable edges only pend; no nesting of maskable interrupts.
    - eoi: in_service=0, go to IDLE.
    - Preempt: nmi_pend and control_state==0 → nested=1, latch the NMI, int_req=1, go to REQ.
  - NMI_SVC (3):
    - eoi with nested=1: nested=0, int_nmi=0, return to MI_SVC with in_service still 1.
    - eoi with nested=0: in_service=0, go to IDLE.
    - A second NMI edge only pends; NMI does not nest inside NMI.
- Ignored inputs: int_ack outside REQ; eoi in IDLE or REQ.
- Latency: an edge sampled at edge n gives pending at n+1 and int_req at n+2 at the earliest. If control_state!=0, int_req is delayed until the first cycle with control_state==0.
- Busy core: a REQ issued while the core stays in non-zero states simply waits. No timeout.

Test Plan:
- Single request, all lines enabled:
  - Stimulus: mask written to 0; irq[2] rises with control_state==0.
  - Response: int_req=1 two cycles later with int_id=2 and int_vector=32'h60. After int_ack: pending[2]=0, in_service=1, state=2. After eoi: state=0.
- Priority: irq[3] and irq[1] rise together → int_id=1. After eoi, a second request follows with int_id=3 and vector 32'h70.
- Masking:
  - With mask=4'b0001, irq[0] rises → pending[0]=1 and int_req stays 0.
  - Writing mask=0 → int_req follows.
- Withdraw: with int_req=1 for id 0, mask[0] is set before ack → int_req=0 next cycle, pending[0] stays 1.
- Preemption:
  - During MI_SVC (id 1), nmi rises → int_req with int_nmi=1 and int_vector=32'h80.
  - Ack → state=3.
  - eoi → state=2 with in_service=1; a second eoi → state=0.
- Boundary gating and reset:
  - irq[0] rises while control_state=5 for 3 cycles → no int_req until control_state=0.
  - rst_n low in REQ → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/irq_priority_controller.sv
// Fixed-priority interrupt controller for the multi-cycle MIPS core: edge-detects
// maskable lines and an NMI, presents the winner at fetch via req/ack, tracks service.
module irq_priority_controller #(
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] MI_VEC_BASE = 32'h0000_0040,
  parameter logic [31:0] VEC_STRIDE  = 32'h0000_0010,
  parameter logic [31:0] NMI_VECTOR  = 32'h0000_0080,
  localparam int         ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               nmi,
  input  logic [3:0]         control_state,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               int_ack,
  input  logic               eoi,
  output logic               int_req,
  output logic               int_nmi,
  output logic [ID_W-1:0]    int_id,
  output logic [31:0]        int_vector,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    MI_SVC  = 3'd2,
    NMI_SVC = 3'd3
  } state_t;

  state_t             fsm_q;
  logic [NUM_IRQ-1:0] irq_hist_p0;
  logic               nmi_hist_p0;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic               nmi_pend_q;
  logic               nested_q;
  logic               int_req_q;
  logic               int_nmi_q;
  logic [ID_W-1:0]    int_id_q;
  logic [31:0]        int_vector_q;
  logic               in_service_q;

  logic [NUM_IRQ-1:0] irq_rise;
  logic               nmi_rise;
  logic [NUM_IRQ-1:0] eligible;
  logic               has_eligible;
  logic [ID_W-1:0]    win_id;
  logic               boundary;
  logic               take_ack;
  logic [NUM_IRQ-1:0] pend_clr;
  logic               nmi_clr;

  // Lowest set index wins; scanning downward leaves the smallest index last.
  function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) id = ID_W'(i);
    end
    return id;
  endfunction

  function automatic logic [31:0] mi_vector(input logic [ID_W-1:0] id);
    return MI_VEC_BASE + 32'(id) * VEC_STRIDE;
  endfunction

  // Stage p0: edge detect against last cycle's line levels
  assign irq_rise     = irq & ~irq_hist_p0;
  assign nmi_rise     = nmi & ~nmi_hist_p0;
  assign eligible     = pending_q & ~mask_q;
  assign has_eligible = |eligible;
  assign win_id       = lowest_set(eligible);
  assign boundary     = (control_state == 4'd0);

  // An acked request retires its pending bit; a same-cycle rising edge re-sets it.
  assign take_ack = (fsm_q == REQ) && int_ack;
  assign pend_clr = (take_ack && !int_nmi_q) ? (NUM_IRQ'(1) << int_id_q) : '0;
  assign nmi_clr  = take_ack && int_nmi_q;

  // Stage p1: pending/mask bookkeeping and the request/service FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q        <= IDLE;
      irq_hist_p0  <= '0;
      nmi_hist_p0  <= 1'b0;
      pending_q    <= '0;
      mask_q       <= '1;
      nmi_pend_q   <= 1'b0;
      nested_q     <= 1'b0;
      int_req_q    <= 1'b0;
      int_nmi_q    <= 1'b0;
      int_id_q     <= '0;
      int_vector_q <= '0;
      in_service_q <= 1'b0;
    end else begin
      irq_hist_p0 <= irq;
      nmi_hist_p0 <= nmi;
      pending_q   <= (pending_q & ~pend_clr) | irq_rise;
      nmi_pend_q  <= (nmi_pend_q & ~nmi_clr) | nmi_rise;
      if (mask_we) mask_q <= mask_wdata;

      case (fsm_q)
        IDLE: begin
          if (boundary && (nmi_pend_q || has_eligible)) begin
            int_req_q <= 1'b1;
            fsm_q     <= REQ;
            if (nmi_pend_q) begin
              int_nmi_q    <= 1'b1;
              int_vector_q <= NMI_VECTOR;
            end else begin
              int_nmi_q    <= 1'b0;
              int_id_q     <= win_id;
              int_vector_q <= mi_vector(win_id);
            end
          end
        end

        REQ: begin
          // Ack beats upgrade/withdraw: the core has already jumped to the vector.
          if (int_ack) begin
            int_req_q    <= 1'b0;
            in_service_q <= 1'b1;
            fsm_q        <= int_nmi_q ? NMI_SVC : MI_SVC;
          end else if (!int_nmi_q && nmi_pend_q) begin
            int_nmi_q    <= 1'b1;
            int_vector_q <= NMI_VECTOR;
          end else if (!int_nmi_q && mask_q[int_id_q]) begin
            int_req_q <= 1'b0;
            fsm_q     <= IDLE;
          end
        end

        MI_SVC: begin
          if (eoi) begin
            in_service_q <= 1'b0;
            fsm_q        <= IDLE;
          end else if (boundary && nmi_pend_q) begin
            nested_q     <= 1'b1;
            int_nmi_q    <= 1'b1;
            int_vector_q <= NMI_VECTOR;
            int_req_q    <= 1'b1;
            fsm_q        <= REQ;
          end
        end

        NMI_SVC: begin
          if (eoi) begin
            if (nested_q) begin
              nested_q     <= 1'b0;
              int_nmi_q    <= 1'b0;
              int_vector_q <= mi_vector(int_id_q);
              fsm_q        <= MI_SVC;
            end else begin
              in_service_q <= 1'b0;
              fsm_q        <= IDLE;
            end
          end
        end

        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign int_req    = int_req_q;
  assign int_nmi    = int_nmi_q;
  assign int_id     = int_id_q;
  assign int_vector = int_vector_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign mask       = mask_q;
  assign state      = fsm_q;

endmodule
